rca_pipe_addsub: RTL and testbench

Parametrised, pipelined ripple-carry adder/subtractor.
- Splits a WIDTH-bit operation into STAGES equal carry-chained chunks, one chunk per clock stage.
- Uses a valid/ready handshake on both sides and one global stall.
- Generalises the single-cycle 32-bit ripple adder with runtime add/sub mode, signed-overflow detection, configurable width/depth and backpressure.
- Sits in the datapath library as the default wide adder for ALU and accumulator blocks.

---
 rtl/arith_pkg.sv | 16 +
 rtl/rca_chunk.sv | 35 +++
 rtl/rca_pipe_addsub.sv | 141 ++++++++++++++
 tb/tb_rca_pipe_addsub.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the datapath adders.
//   op_t / OP_ADD / OP_SUB : add/subtract mode encoding
//   split_ok()             : elaboration-time legality of a WIDTH/STAGES split
package arith_pkg;

  typedef logic op_t;

  localparam op_t OP_ADD = 1'b0;
  localparam op_t OP_SUB = 1'b1;

  // A width can be cut into 'stages' equal chunks of at least one bit each.
  function automatic bit split_ok(int width, int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/rca_chunk.sv
// Combinational CW-bit ripple-carry full-adder chain.
//   a, b      in  CW  chunk operands
//   cin       in  1   carry into bit 0
//   s         out CW  chunk sum
//   cout      out 1   carry out of the top bit
//   c_msb_in  out 1   carry into the top bit (for signed overflow)
module rca_chunk #(
  parameter int CW = 8
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] s,
  output logic          cout,
  output logic          c_msb_in
);

  // Carry chain kept inside one process so the ripple is a plain
  // sequential evaluation rather than a self-referencing vector.
  logic [CW:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < CW; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout     = c[CW];
  assign c_msb_in = c[CW-1];

endmodule

// File: rtl/rca_pipe_addsub.sv
// Pipelined ripple-carry adder/subtractor, STAGES chunks of CW = WIDTH/STAGES
// bits, one chunk per clock stage, valid/ready on both sides, global stall.
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (in_ready depends only on output side)
//   input_a, input_b    operands
//   carryin             carry-in, add mode only
//   op                  OP_ADD / OP_SUB
//   out_valid/out_ready result handshake
//   sum, carryout       result and carry out of MSB (SUB: 1 = no borrow)
//   overflow            signed two's-complement overflow
module rca_pipe_addsub
  import arith_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  input  logic             carryin,
  input  op_t              op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow
);

  localparam int CW = WIDTH / STAGES;

  if (!split_ok(WIDTH, STAGES)) begin : g_cfg_chk
    $error("rca_pipe_addsub: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
  end

  // Whole pipe advances together; a full, unaccepted output freezes it.
  logic              en;
  logic [STAGES-1:0] vld_pipe;

  assign en        = !vld_pipe[STAGES-1] | out_ready;
  assign in_ready  = en;
  assign out_valid = vld_pipe[STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
    end else if (en) begin
      vld_pipe[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  // Subtract is A + ~B + 1; carryin has no effect in that mode.
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  assign b_eff = (op == OP_SUB) ? ~input_b : input_b;
  assign c0    = (op == OP_SUB) ? 1'b1 : carryin;

  // Stage k consumes the low CW bits of the pending operands, appends its sum
  // chunk above the sums already done, and forwards only the still-unprocessed
  // upper operand bits. Register widths therefore shrink/grow per stage.
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO = k * CW;      // sum bits finished before this stage
    localparam int HI = WIDTH - LO;  // operand bits still pending here

    logic [HI-1:0]    a_i;
    logic [HI-1:0]    b_i;
    logic             c_i;
    logic [CW-1:0]    s_c;
    logic             co;
    logic             cm;
    logic [LO+CW-1:0] s_nx;
    logic [LO+CW-1:0] s_q;
    logic             c_q;

    if (k == 0) begin : g_in
      assign a_i  = input_a;
      assign b_i  = b_eff;
      assign c_i  = c0;
      assign s_nx = s_c;
    end else begin : g_in
      assign a_i  = g_st[k-1].g_fwd.a_q;
      assign b_i  = g_st[k-1].g_fwd.b_q;
      assign c_i  = g_st[k-1].c_q;
      assign s_nx = {s_c, g_st[k-1].s_q};
    end

    rca_chunk #(.CW(CW)) u_chunk (
      .a        (a_i[CW-1:0]),
      .b        (b_i[CW-1:0]),
      .cin      (c_i),
      .s        (s_c),
      .cout     (co),
      .c_msb_in (cm)
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        s_q <= '0;
        c_q <= 1'b0;
      end else if (en) begin
        s_q <= s_nx;
        c_q <= co;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [HI-CW-1:0] a_q;
      logic [HI-CW-1:0] b_q;
      logic             cm_unused;

      // Only the final chunk's top-bit carry matters for overflow.
      assign cm_unused = cm;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_i[HI-1:CW];
          b_q <= b_i[HI-1:CW];
        end
      end
    end else begin : g_tail
      logic ov_q;

      always_ff @(posedge clk) begin
        if (rst)     ov_q <= 1'b0;
        else if (en) ov_q <= co ^ cm;
      end
    end
  end

  assign sum      = g_st[STAGES-1].s_q;
  assign carryout = g_st[STAGES-1].c_q;
  assign overflow = g_st[STAGES-1].g_tail.ov_q;

endmodule

// File: tb/tb_rca_pipe_addsub.sv
module tb_rca_pipe_addsub;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main DUT: 32 bits, 4 stages
  logic        in_valid = 1'b0, in_ready, carryin = 1'b0, op = 1'b0;
  logic [31:0] input_a = '0, input_b = '0, sum;
  logic        out_valid, out_ready = 1'b1, carryout, overflow;

  // 8 bits, 1 stage
  logic       v8 = 1'b0, r8, cin8 = 1'b0, op8 = 1'b0, ov8_valid, co8, of8;
  logic [7:0] a8 = '0, b8 = '0, s8;

  // 64 bits, 8 stages
  logic        v64 = 1'b0, r64, cin64 = 1'b0, op64 = 1'b0, ov64_valid, co64, of64;
  logic [63:0] a64 = '0, b64 = '0, s64;

  rca_pipe_addsub #(.WIDTH(32), .STAGES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .input_a(input_a), .input_b(input_b), .carryin(carryin), .op(op),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .carryout(carryout), .overflow(overflow));

  rca_pipe_addsub #(.WIDTH(8), .STAGES(1)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8),
    .input_a(a8), .input_b(b8), .carryin(cin8), .op(op8),
    .out_valid(ov8_valid), .out_ready(1'b1), .sum(s8),
    .carryout(co8), .overflow(of8));

  rca_pipe_addsub #(.WIDTH(64), .STAGES(8)) dut64 (
    .clk(clk), .rst(rst), .in_valid(v64), .in_ready(r64),
    .input_a(a64), .input_b(b64), .carryin(cin64), .op(op64),
    .out_valid(ov64_valid), .out_ready(1'b1), .sum(s64),
    .carryout(co64), .overflow(of64));

  typedef struct {
    logic [31:0] a, b;
    logic        cin, op;
    logic [31:0] sum;
    logic        co, ov;
  } vec_t;

  typedef struct {
    logic [31:0] sum;
    logic        co, ov;
  } res_t;

  vec_t tbl [10];
  res_t q[$];
  int   checks = 0, errors = 0;
  int   cyc = 0, pops = 0, first_pop = -1, last_pop = -1, first_push = -1, ghosts = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain (W+1)-bit addition; overflow from operand/result signs.
  function automatic res_t model(logic [31:0] a, logic [31:0] b, logic cin, logic sub);
    res_t        r;
    logic [31:0] bb;
    logic [32:0] full;
    bb     = sub ? ~b : b;
    full   = {1'b0, a} + {1'b0, bb} + {32'd0, (sub ? 1'b1 : cin)};
    r.sum  = full[31:0];
    r.co   = full[32];
    r.ov   = (a[31] == bb[31]) && (full[31] != a[31]);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle on the main DUT: score handshakes about to happen, then clock.
  task automatic step();
    res_t e;
    if (rst) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          ghosts++;
          $display("FAIL ghost_out: got sum %0h expected no result", sum);
        end else begin
          e = q.pop_front();
          chk("sb_sum", 64'(sum), 64'(e.sum));
          chk("sb_carryout", 64'(carryout), 64'(e.co));
          chk("sb_overflow", 64'(overflow), 64'(e.ov));
          pops++;
          if (first_pop < 0) first_pop = cyc;
          last_pop = cyc;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(input_a, input_b, carryin, op));
        if (first_push < 0) first_push = cyc;
      end
    end
    tick();
    cyc++;
  endtask

  task automatic drive(logic [31:0] a, logic [31:0] b, logic c, logic o);
    input_a = a; input_b = b; carryin = c; op = o; in_valid = 1'b1;
  endtask

  task automatic drain(string name);
    for (int n = 0; n < 12 && q.size() != 0; n++) step();
    chk(name, 64'(q.size()), 64'd0);
  endtask

  initial begin
    tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    tbl[1] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    tbl[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    tbl[3] = '{32'h0000_0001, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0003, 1'b0, 1'b0};
    tbl[4] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    tbl[5] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    tbl[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    tbl[7] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0};
    tbl[8] = '{32'h1234_5678, 32'h1234_5679, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
    tbl[9] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};

    // reset state
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_carryout", 64'(carryout), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_out_valid_w8", 64'(ov8_valid), 64'd0);
    chk("rst_out_valid_w64", 64'(ov64_valid), 64'd0);

    // directed vectors, one at a time: exact 4-cycle latency and values
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].op);
      step();
      in_valid = 1'b0;
      step(); step();
      chk($sformatf("vec%0d_not_early", i), 64'(out_valid), 64'd0);
      step();
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("vec%0d_sum", i), 64'(sum), 64'(tbl[i].sum));
      chk($sformatf("vec%0d_carryout", i), 64'(carryout), 64'(tbl[i].co));
      chk($sformatf("vec%0d_overflow", i), 64'(overflow), 64'(tbl[i].ov));
    end
    step();
    chk("vec_drained", 64'(q.size()), 64'd0);

    // back-to-back stream of 16 beats, full throughput
    pops = 0; first_pop = -1; last_pop = -1; first_push = -1;
    for (int i = 0; i < 16; i++) begin
      drive($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      step();
    end
    in_valid = 1'b0;
    drain("stream_drained");
    chk("stream_count", 64'(pops), 64'd16);
    chk("stream_fill", 64'(first_pop - first_push), 64'd4);
    chk("stream_no_gaps", 64'(last_pop - first_pop), 64'd15);

    // backpressure: fill, stall 5 cycles, then release
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(32'h1111_0000 * (i + 1), 32'h0F0F_0F0F + i, 1'b1, 1'(i & 1));
      step();
    end
    drive(32'hDEAD_BEEF, 32'h1, 1'b0, 1'b0);
    for (int s = 0; s < 5; s++) begin
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_sum_held", 64'(sum), 64'(q[0].sum));
      chk("bp_carry_held", 64'(carryout), 64'(q[0].co));
      chk("bp_ovf_held", 64'(overflow), 64'(q[0].ov));
      step();
    end
    chk("bp_accepted", 64'(q.size()), 64'd4);
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain("bp_drained");

    // reset with 3 beats in flight; a beat offered during reset is dropped
    ghosts = 0;
    for (int i = 0; i < 3; i++) begin
      drive(32'hA000_0000 + i, 32'h5, 1'b0, 1'b0);
      step();
    end
    drive(32'hBBBB_BBBB, 32'h1, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    for (int s = 0; s < 8; s++) begin
      chk("midrst_flushed", 64'(out_valid), 64'd0);
      step();
    end
    chk("midrst_no_ghosts", 64'(ghosts), 64'd0);

    // WIDTH=8, STAGES=1: single registered adder
    a8 = 8'h7F; b8 = 8'h01; op8 = 1'b0; cin8 = 1'b0; v8 = 1'b1;
    tick();
    chk("w8_add_valid", 64'(ov8_valid), 64'd1);
    chk("w8_add_sum", 64'(s8), 64'h80);
    chk("w8_add_ovf", 64'(of8), 64'd1);
    chk("w8_add_co", 64'(co8), 64'd0);
    a8 = 8'h80; b8 = 8'h01; op8 = 1'b1; cin8 = 1'b0;
    tick();
    chk("w8_sub_sum", 64'(s8), 64'h7F);
    chk("w8_sub_ovf", 64'(of8), 64'd1);
    chk("w8_sub_co", 64'(co8), 64'd1);
    a8 = 8'hFF; b8 = 8'h01; op8 = 1'b0; cin8 = 1'b0;
    tick();
    v8 = 1'b0;
    chk("w8_wrap_sum", 64'(s8), 64'h00);
    chk("w8_wrap_co", 64'(co8), 64'd1);
    chk("w8_wrap_ovf", 64'(of8), 64'd0);

    // WIDTH=64, STAGES=8: carry ripples through all eight chunks
    a64 = '1; b64 = 64'd1; op64 = 1'b0; cin64 = 1'b0; v64 = 1'b1;
    tick();
    v64 = 1'b0;
    repeat (6) tick();
    chk("w64_not_early", 64'(ov64_valid), 64'd0);
    tick();
    chk("w64_valid", 64'(ov64_valid), 64'd1);
    chk("w64_sum", s64, 64'd0);
    chk("w64_co", 64'(co64), 64'd1);
    chk("w64_ovf", 64'(of64), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors + ghosts);
    $finish;
  end

  // Hard stop if something upstream wedges.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
